// File: rtl/proc_state_regs_if.sv
// Bundle between the control FSM / datapath and the special-register block.
//  slave  : seen by proc_state_regs (commands and flags in, register views out)
//  master : seen by the controller driving the block
// Signals:
//  cmp_f_en, of_f_en, z_f_en   flag-group write enables (L/N, F/C, Z)
//  C_in, L_in, F_in, Z_in, N_in flag values from the datapath
//  pc_op, pc_in                 PC operation and jump/call target
//  instr_en, instr_in           instruction register load
//  call, ret, irq, rti          control-flow commands
//  psr, pc, instr               register views
//  stk_empty, stk_full, stk_err return-stack status
//  dbg_state                    current FSM state (0 = RUN, 1 = ISR)
// There is no valid/ready pairing on this bundle: every command is a level
// sampled on each rising clock edge and always accepted in that cycle, and
// every output is valid at all times.
interface proc_state_regs_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               cmp_f_en;
  logic               of_f_en;
  logic               z_f_en;
  logic               C_in;
  logic               L_in;
  logic               F_in;
  logic               Z_in;
  logic               N_in;
  logic [1:0]         pc_op;
  logic [ADDR_W-1:0]  pc_in;
  logic               instr_en;
  logic [INSTR_W-1:0] instr_in;
  logic               call;
  logic               ret;
  logic               irq;
  logic               rti;
  logic [15:0]        psr;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr;
  logic               stk_empty;
  logic               stk_full;
  logic               stk_err;
  logic               dbg_state;

  modport slave (
    input  cmp_f_en, of_f_en, z_f_en, C_in, L_in, F_in, Z_in, N_in,
           pc_op, pc_in, instr_en, instr_in, call, ret, irq, rti,
    output psr, pc, instr, stk_empty, stk_full, stk_err, dbg_state
  );

  modport master (
    output cmp_f_en, of_f_en, z_f_en, C_in, L_in, F_in, Z_in, N_in,
           pc_op, pc_in, instr_en, instr_in, call, ret, irq, rti,
    input  psr, pc, instr, stk_empty, stk_full, stk_err, dbg_state
  );
endinterface

// File: rtl/proc_state_regs.sv
// Processor special-register block: PSR flags, PC, instruction register,
// a hardware return-address stack and single-level interrupt entry/exit
// with shadow PC/PSR.
// Ports:
//  clk    rising-edge clock for all state
//  reset  asynchronous active-high reset
//  sr     proc_state_regs_if.slave bundle (commands in, register views out)
// PSR layout: C=bit0 L=bit2 F=bit5 Z=bit6 N=bit7 I=bit15, other bits zero.
module proc_state_regs #(
  parameter int              ADDR_W    = 16,
  parameter int              INSTR_W   = 16,
  parameter int              RET_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] INT_VEC  = ADDR_W'('h0100)
) (
  input  logic clk,
  input  logic reset,
  proc_state_regs_if.slave sr
);

  localparam int PW = $clog2(RET_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [15:0]         psr_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [CW-1:0]       cnt_q;
  logic [ADDR_W-1:0]   mem_q [RET_DEPTH];
  logic [ADDR_W-1:0]   shadow_pc_q;
  logic [15:0]         shadow_psr_q;
  logic                err_q;

  logic [15:0]         psr_d;
  logic [ADDR_W-1:0]   pc_inc;
  logic [PW-1:0]       top_idx;
  logic                stk_full;
  logic                stk_empty;

  // PSR with only the enabled flag groups replaced; I bit carried through.
  always_comb begin
    psr_d = psr_q;
    if (sr.cmp_f_en) begin
      psr_d[2] = sr.L_in;
      psr_d[7] = sr.N_in;
    end
    if (sr.of_f_en) begin
      psr_d[0] = sr.C_in;
      psr_d[5] = sr.F_in;
    end
    if (sr.z_f_en) begin
      psr_d[6] = sr.Z_in;
    end
  end

  assign pc_inc    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  // When the stack is full the low bits of cnt_q wrap to 0, so subtracting 1
  // still lands on the last entry.
  assign top_idx   = cnt_q[PW-1:0] - {{(PW-1){1'b0}}, 1'b1};
  assign stk_full  = (cnt_q == CW'(RET_DEPTH));
  assign stk_empty = (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      psr_q        <= '0;
      instr_q      <= '0;
      cnt_q        <= '0;
      shadow_pc_q  <= '0;
      shadow_psr_q <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < RET_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (sr.instr_en) instr_q <= sr.instr_in;

      if (state_q == ST_RUN && sr.irq) begin
        // Resume address is the current PC: the interrupted instruction
        // has not been advanced past.
        shadow_pc_q  <= pc_q;
        shadow_psr_q <= psr_d;
        pc_q         <= INT_VEC;
        psr_q        <= 16'h8000;
        state_q      <= ST_ISR;
      end else if (state_q == ST_ISR && sr.rti) begin
        pc_q    <= shadow_pc_q;
        psr_q   <= shadow_psr_q & 16'h7FFF;
        state_q <= ST_RUN;
      end else begin
        if (sr.rti) err_q <= 1'b1;
        psr_q <= psr_d;
        if (sr.call && sr.ret) begin
          err_q <= 1'b1;
        end else if (sr.call) begin
          if (!stk_full) begin
            mem_q[cnt_q[PW-1:0]] <= pc_inc;
            cnt_q                <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            pc_q                 <= sr.pc_in;
          end else begin
            pc_q  <= pc_inc;
            err_q <= 1'b1;
          end
        end else if (sr.ret) begin
          if (!stk_empty) begin
            pc_q  <= mem_q[top_idx];
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end else begin
            pc_q  <= pc_inc;
            err_q <= 1'b1;
          end
        end else begin
          case (sr.pc_op)
            2'b01:   pc_q <= pc_inc;
            2'b10:   pc_q <= sr.pc_in;
            default: pc_q <= pc_q;
          endcase
        end
      end
    end
  end

  assign sr.psr       = psr_q;
  assign sr.pc        = pc_q;
  assign sr.instr     = instr_q;
  assign sr.stk_empty = stk_empty;
  assign sr.stk_full  = stk_full;
  assign sr.stk_err   = err_q;
  assign sr.dbg_state = state_q;

endmodule

// File: tb/tb_proc_state_regs.sv
module tb_proc_state_regs;

  localparam int AW    = 16;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int RPC   = 0;
  localparam int IVEC  = 'h0100;
  localparam int EW    = AW + 16 + 3 + IW;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_fail;

  proc_state_regs_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  proc_state_regs #(
    .ADDR_W(AW), .INSTR_W(IW), .RET_DEPTH(DEPTH),
    .RESET_PC(AW'(RPC)), .INT_VEC(AW'(IVEC))
  ) dut (
    .clk(clk),
    .reset(reset),
    .sr(bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  en;      // {cmp, of, z}
    logic [4:0]  fl;      // {C, L, F, Z, N}
    logic [1:0]  pc_op;
    logic [15:0] pc_in;
    logic [3:0]  cmd;     // {call, ret, irq, rti}
    logic [15:0] exp_pc;
    logic [15:0] exp_psr;
    logic [2:0]  exp_stk; // {empty, full, err}
  } vec_t;

  vec_t vecs[$];
  logic [EW-1:0] exp_q[$];

  // driver tasks
  task automatic drive(input logic [2:0] en, input logic [4:0] fl,
                       input logic [1:0] op, input logic [15:0] tgt,
                       input logic [3:0] cmd);
    {bus.cmp_f_en, bus.of_f_en, bus.z_f_en} = en;
    {bus.C_in, bus.L_in, bus.F_in, bus.Z_in, bus.N_in} = fl;
    bus.pc_op = op;
    bus.pc_in = tgt;
    {bus.call, bus.ret, bus.irq, bus.rti} = cmd;
  endtask

  task automatic idle();
    drive(3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0000);
    bus.instr_en = 1'b0;
    bus.instr_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic [15:0] pc,
                           input logic [15:0] psr, input logic [2:0] stk);
    chk({nm, ".pc"},  32'(bus.pc), 32'(pc));
    chk({nm, ".psr"}, 32'(bus.psr), 32'(psr));
    chk({nm, ".stk"}, 32'({bus.stk_empty, bus.stk_full, bus.stk_err}), 32'(stk));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    chk_state("reset", 16'(RPC), 16'h0000, 3'b100);
    chk("reset.instr", 32'(bus.instr), 32'h0);
    step();
    reset = 1'b0;
  endtask

  // behavioural reference model
  int     m_pc, m_spc, m_instr;
  bit     m_isr, m_err;
  bit [4:0] m_fl, m_sfl; // {C, L, F, Z, N}
  int     m_stk[$];

  function automatic logic [15:0] m_psr(input bit isr, input bit [4:0] f);
    return 16'((int'(isr) << 15) | (int'(f[0]) << 7) | (int'(f[1]) << 6) |
               (int'(f[2]) << 5) | (int'(f[3]) << 2) | int'(f[4]));
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_spc = 0; m_instr = 0;
    m_isr = 0; m_err = 0; m_fl = '0; m_sfl = '0;
    m_stk.delete();
  endtask

  task automatic model_step();
    bit [4:0] nf;
    nf = m_fl;
    if (bus.cmp_f_en) begin nf[3] = bus.L_in; nf[0] = bus.N_in; end
    if (bus.of_f_en)  begin nf[4] = bus.C_in; nf[2] = bus.F_in; end
    if (bus.z_f_en)   nf[1] = bus.Z_in;
    if (bus.instr_en) m_instr = int'(bus.instr_in);
    if (!m_isr && bus.irq) begin
      m_spc = m_pc; m_sfl = nf; m_pc = IVEC; m_fl = '0; m_isr = 1;
    end else if (m_isr && bus.rti) begin
      m_pc = m_spc; m_fl = m_sfl; m_isr = 0;
    end else begin
      if (bus.rti) m_err = 1;
      m_fl = nf;
      if (bus.call && bus.ret) m_err = 1;
      else if (bus.call) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_pc + 1) % 65536);
          m_pc = int'(bus.pc_in);
        end else begin
          m_pc = (m_pc + 1) % 65536; m_err = 1;
        end
      end else if (bus.ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = (m_pc + 1) % 65536; m_err = 1; end
      end else if (bus.pc_op == 2'b01) m_pc = (m_pc + 1) % 65536;
      else if (bus.pc_op == 2'b10) m_pc = int'(bus.pc_in);
    end
    exp_q.push_back({16'(m_pc), m_psr(m_isr, m_fl),
                     m_stk.size() == 0, m_stk.size() == DEPTH, m_err, 16'(m_instr)});
  endtask

  initial begin
    logic [EW-1:0] e;
    n_vec = 0;
    n_fail = 0;
    reset = 1'b1;
    idle();

    // directed table, applied from reset
    vecs.push_back('{3'b000, 5'b00000, 2'b01, 16'h0000, 4'b0000, 16'h0001, 16'h0000, 3'b100});
    vecs.push_back('{3'b000, 5'b00000, 2'b01, 16'h0000, 4'b0000, 16'h0002, 16'h0000, 3'b100});
    vecs.push_back('{3'b000, 5'b00000, 2'b01, 16'h0000, 4'b0000, 16'h0003, 16'h0000, 3'b100});
    vecs.push_back('{3'b000, 5'b00000, 2'b10, 16'hFFFF, 4'b0000, 16'hFFFF, 16'h0000, 3'b100});
    vecs.push_back('{3'b000, 5'b00000, 2'b01, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 3'b100});
    vecs.push_back('{3'b011, 5'b10010, 2'b00, 16'h0000, 4'b0000, 16'h0000, 16'h0041, 3'b100});
    vecs.push_back('{3'b100, 5'b00001, 2'b00, 16'h0000, 4'b0000, 16'h0000, 16'h00C1, 3'b100});
    vecs.push_back('{3'b000, 5'b00000, 2'b10, 16'h0010, 4'b0000, 16'h0010, 16'h00C1, 3'b100});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0040, 4'b1000, 16'h0040, 16'h00C1, 3'b000});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0100, 16'h0011, 16'h00C1, 3'b100});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0200, 4'b1000, 16'h0200, 16'h00C1, 3'b000});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0300, 4'b1000, 16'h0300, 16'h00C1, 3'b000});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0400, 4'b1000, 16'h0400, 16'h00C1, 3'b000});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0500, 4'b1000, 16'h0500, 16'h00C1, 3'b010});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0600, 4'b1000, 16'h0501, 16'h00C1, 3'b011});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0100, 16'h0401, 16'h00C1, 3'b001});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0100, 16'h0301, 16'h00C1, 3'b001});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0100, 16'h0201, 16'h00C1, 3'b001});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0100, 16'h0012, 16'h00C1, 3'b101});
    vecs.push_back('{3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0100, 16'h0013, 16'h00C1, 3'b101});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].fl, vecs[i].pc_op, vecs[i].pc_in, vecs[i].cmd);
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_psr, vecs[i].exp_stk);
    end

    // ret on an empty stack from a clean reset
    do_reset();
    drive(3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0100);
    step();
    chk_state("ret_empty", 16'h0001, 16'h0000, 3'b101);

    // call and ret together: no PC/stack change, flags still update
    do_reset();
    drive(3'b000, 5'b00000, 2'b10, 16'h0005, 4'b0000);
    step();
    drive(3'b010, 5'b10000, 2'b01, 16'h0077, 4'b1100);
    step();
    chk_state("call_ret", 16'h0005, 16'h0001, 3'b101);

    // interrupt entry, held irq, return
    do_reset();
    drive(3'b011, 5'b10010, 2'b10, 16'h0022, 4'b0000);
    step();
    chk_state("pre_irq", 16'h0022, 16'h0041, 3'b100);
    drive(3'b001, 5'b00000, 2'b00, 16'h0000, 4'b0010);
    step();
    chk_state("irq_entry", 16'(IVEC), 16'h8000, 3'b100);
    chk("irq_state", 32'(bus.dbg_state), 32'h1);
    drive(3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0010);
    step();
    chk_state("irq_held", 16'(IVEC), 16'h8000, 3'b100);
    drive(3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0001);
    step();
    chk_state("rti", 16'h0022, 16'h0001, 3'b100);
    drive(3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0001);
    step();
    chk_state("rti_in_run", 16'h0022, 16'h0001, 3'b101);

    // asynchronous reset inside the handler after two calls
    do_reset();
    drive(3'b000, 5'b00000, 2'b00, 16'h0000, 4'b0010);
    step();
    drive(3'b000, 5'b00000, 2'b00, 16'h0300, 4'b1000);
    step();
    drive(3'b000, 5'b00000, 2'b00, 16'h0400, 4'b1000);
    step();
    chk_state("isr_calls", 16'h0400, 16'h8000, 3'b000);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk_state("reset_in_isr", 16'(RPC), 16'h0000, 3'b100);
    chk("reset_in_isr.state", 32'(bus.dbg_state), 32'h0);
    step();
    reset = 1'b0;

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      drive(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
            {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0});
      bus.instr_en = 1'($urandom_range(0, 1));
      bus.instr_in = 16'($urandom_range(0, 65535));
      model_step();
      step();
      e = exp_q.pop_front();
      chk("rnd.pc",    32'(bus.pc), 32'(e[EW-1 -: 16]));
      chk("rnd.psr",   32'(bus.psr), 32'(e[EW-17 -: 16]));
      chk("rnd.stk",   32'({bus.stk_empty, bus.stk_full, bus.stk_err}), 32'(e[IW+2 -: 3]));
      chk("rnd.instr", 32'(bus.instr), 32'(e[IW-1:0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
